subservient_dbg_loader: RTL

//  Wishbone initiator for the subservient_core debug port (i_debug_mode, i_wb_dbg_*).

---
 rtl/subservient_dbg_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/subservient_dbg_loader.sv
// subservient_dbg_loader: packs a byte stream into words and writes them over the subservient debug Wishbone port
// while holding the CPU in reset; define SUBSERVIENT_DBG_LOADER_VERIFY_EN to read back and compare every word.
module subservient_dbg_loader #(
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter int          LEN_W    = 16,
  parameter int          TIMEOUT  = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic             o_debug_mode,
  output logic             o_cpu_rst,
  output logic [31:0]      o_wb_dbg_adr,
  output logic [31:0]      o_wb_dbg_dat,
  output logic [3:0]       o_wb_dbg_sel,
  output logic             o_wb_dbg_we,
  output logic             o_wb_dbg_stb,
  input  logic [31:0]      i_wb_dbg_rdt,
  input  logic             i_wb_dbg_ack,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef SUBSERVIENT_DBG_LOADER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, VERIFY, FINISH} state_t;
`else
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, FINISH} state_t;
  logic unused_rdt;
  assign unused_rdt = ^i_wb_dbg_rdt;
`endif
  state_t           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [TW-1:0]    tmr_q;
  logic [31:0]      adr_q, dat_q;
  logic             dbg_q, crst_q, stb_q, we_q, rdy_q, done_q, err_q;
  logic             ack, expired, last;
  assign ack     = stb_q & i_wb_dbg_ack;
  assign expired = stb_q & ~i_wb_dbg_ack & (tmr_q == TW'(TIMEOUT - 1));
  assign last    = cnt_q == LEN_W'(1);
  always_ff @(posedge i_clk) begin
    done_q <= 1'b0;
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      adr_q   <= BASE_ADR;
      dat_q   <= '0;
      dbg_q   <= 1'b0;
      crst_q  <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // the timer is held at zero between strobes, so each strobe gets a fresh budget
      tmr_q <= stb_q ? tmr_q + 1'b1 : '0;
      case (state_q)
        IDLE: if (i_start) begin
          err_q <= 1'b0;
          if (i_len != '0) begin
            cnt_q   <= i_len;
            adr_q   <= BASE_ADR;
            idx_q   <= '0;
            dbg_q   <= 1'b1;
            crst_q  <= 1'b1;
            rdy_q   <= 1'b1;
            state_q <= COLLECT;
          end else done_q <= 1'b1;
        end
        COLLECT: if (i_byte_valid) begin
          dat_q[8*idx_q +: 8] <= i_byte;
          idx_q <= idx_q + 1'b1;
          if (idx_q == 2'd3) begin
            rdy_q   <= 1'b0;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: if (expired) begin
          stb_q   <= 1'b0;
          err_q   <= 1'b1;
          state_q <= FINISH;
        end else if (ack) begin
          stb_q <= 1'b0;
`ifdef SUBSERVIENT_DBG_LOADER_VERIFY_EN
          state_q <= VERIFY;
`else
          adr_q   <= adr_q + 32'd4;
          cnt_q   <= cnt_q - 1'b1;
          rdy_q   <= ~last;
          state_q <= last ? FINISH : COLLECT;
`endif
        end
`ifdef SUBSERVIENT_DBG_LOADER_VERIFY_EN
        VERIFY: if (!stb_q) begin
          stb_q <= 1'b1;
          we_q  <= 1'b0;
        end else if (expired) begin
          stb_q   <= 1'b0;
          err_q   <= 1'b1;
          state_q <= FINISH;
        end else if (ack) begin
          stb_q   <= 1'b0;
          err_q   <= err_q | (i_wb_dbg_rdt != dat_q);
          adr_q   <= adr_q + 32'd4;
          cnt_q   <= cnt_q - 1'b1;
          rdy_q   <= ~last;
          state_q <= last ? FINISH : COLLECT;
        end
`endif
        FINISH: begin
          dbg_q   <= 1'b0;
          crst_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_byte_ready = rdy_q;
  assign o_debug_mode = dbg_q;
  assign o_cpu_rst    = crst_q;
  assign o_wb_dbg_adr = adr_q;
  assign o_wb_dbg_dat = dat_q;
  assign o_wb_dbg_sel = 4'hf;
  assign o_wb_dbg_we  = we_q;
  assign o_wb_dbg_stb = stb_q;
  assign o_busy       = state_q != IDLE;
  assign o_done       = done_q;
  assign o_err        = err_q;
endmodule
